// File: rtl/demux_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_seq_pkg
// Description : Shared definitions for the demux_seq_4ch sequencer: channel
//               count, select width, FSM state encoding and the dwell
//               counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_seq_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Counter must hold values 0..HOLD_CYCLES-1 (plus headroom for the
  // reload value); an illegal HOLD_CYCLES still yields a legal 1-bit width
  // so the range check can report it cleanly.
  function automatic int cnt_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_seq_dwell_cnt.sv
`default_nettype none
// ============================================================================
// Module      : demux_seq_dwell_cnt
// Description : Loadable down-counter that measures how long a word stays
//               presented. Loads on i_load, otherwise counts down and
//               saturates at zero.
// Ports       : clk       - clock
//               rst       - asynchronous active-high reset (count -> 0)
//               i_load    - load enable (wins over decrement)
//               i_load_val- value loaded on i_load
//               o_cnt     - current count
//               o_zero    - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module demux_seq_dwell_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/demux_seq_4ch.sv
`default_nettype none
// ============================================================================
// Module      : demux_seq_4ch
// Description : Upstream sequencer for a 4-channel demultiplexer. Accepts
//               words over valid/ready, assigns them to channels round-robin
//               and presents each (registered) word for HOLD_CYCLES cycles.
// Config      : DEMUX_SEQ_TAG_EN - when defined, adds input piSel and the
//               channel is taken from it instead of the round-robin pointer.
// Ports       : piClk    - clock
//               piRst    - asynchronous active-high reset
//               piData   - input word
//               piSel    - explicit channel (DEMUX_SEQ_TAG_EN only)
//               piValid  - piData valid
//               poReady  - word accepted this cycle if piValid
//               poE      - word presented to the demux
//               poSel    - channel of poE
//               poStrobe - pulse: poE/poSel just updated
//               poWrap   - pulse with poStrobe when poSel updated to 3
//               poBusy   - FSM in HOLD
// Revision    : 1.0 - initial release
// ============================================================================
module demux_seq_4ch
  import demux_seq_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              piClk,
  input  logic              piRst,
  input  logic [DATA_W-1:0] piData,
`ifdef DEMUX_SEQ_TAG_EN
  input  logic [SEL_W-1:0]  piSel,
`endif
  input  logic              piValid,
  output logic              poReady,
  output logic [DATA_W-1:0] poE,
  output logic [SEL_W-1:0]  poSel,
  output logic              poStrobe,
  output logic              poWrap,
  output logic              poBusy
);

  localparam int               CNT_W    = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_hold_range_err
    $error("demux_seq_4ch: HOLD_CYCLES must be in 1..255");
  end

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  e_q, e_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               strobe_q, strobe_d;
  logic               wrap_q, wrap_d;

  logic               cnt_zero;
  logic [CNT_W-1:0]   cnt_val;
  logic               ready;
  logic               accept;

  // Ready depends on state only, so upstream can never create a
  // combinational loop through piValid.
  assign ready  = (state_q == ST_IDLE) || cnt_zero;
  assign accept = piValid && ready;

  demux_seq_dwell_cnt #(
    .CNT_W (CNT_W)
  ) u_dwell_cnt (
    .clk        (piClk),
    .rst        (piRst),
    .i_load     (accept),
    .i_load_val (LOAD_VAL),
    .o_cnt      (cnt_val),
    .o_zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    e_d      = e_q;
    sel_d    = sel_q;
    strobe_d = 1'b0;
    wrap_d   = 1'b0;

    if (accept) begin
      e_d      = piData;
      strobe_d = 1'b1;
      state_d  = ST_HOLD;
`ifdef DEMUX_SEQ_TAG_EN
      sel_d    = piSel;
      wrap_d   = (piSel == SEL_W'(NUM_CH - 1));
      ptr_d    = '0;
`else
      sel_d    = ptr_q;
      wrap_d   = (ptr_q == SEL_W'(NUM_CH - 1));
      ptr_d    = ptr_q + 1'b1;   // natural 2-bit wrap 3 -> 0
`endif
    end else if (state_q == ST_HOLD && cnt_zero) begin
      // Dwell expired with nothing offered: fall back to IDLE.
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge piClk or posedge piRst) begin
    if (piRst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      e_q      <= '0;
      sel_q    <= '0;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      e_q      <= e_d;
      sel_q    <= sel_d;
      strobe_q <= strobe_d;
      wrap_q   <= wrap_d;
    end
  end

  assign poReady  = ready;
  assign poE      = e_q;
  assign poSel    = sel_q;
  assign poStrobe = strobe_q;
  assign poWrap   = wrap_q;
  assign poBusy   = (state_q == ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_demux_seq_4ch.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_seq_4ch
// Description : Self-checking bench for demux_seq_4ch. Instance u_dut4 uses
//               HOLD_CYCLES=4, u_dut1 uses HOLD_CYCLES=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_seq_4ch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       valid4 = 1'b0;
  logic [3:0] data4  = '0;
  logic [1:0] sel4   = '0;
  logic       ready4, strobe4, wrap4, busy4;
  logic [3:0] e4;
  logic [1:0] osel4;

  logic       valid1 = 1'b0;
  logic [3:0] data1  = '0;
  logic [1:0] sel1   = '0;
  logic       ready1, strobe1, wrap1, busy1;
  logic [3:0] e1;
  logic [1:0] osel1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux_seq_4ch #(.DATA_W(4), .HOLD_CYCLES(4)) u_dut4 (
    .piClk    (clk),
    .piRst    (rst),
    .piData   (data4),
`ifdef DEMUX_SEQ_TAG_EN
    .piSel    (sel4),
`endif
    .piValid  (valid4),
    .poReady  (ready4),
    .poE      (e4),
    .poSel    (osel4),
    .poStrobe (strobe4),
    .poWrap   (wrap4),
    .poBusy   (busy4)
  );

  demux_seq_4ch #(.DATA_W(4), .HOLD_CYCLES(1)) u_dut1 (
    .piClk    (clk),
    .piRst    (rst),
    .piData   (data1),
`ifdef DEMUX_SEQ_TAG_EN
    .piSel    (sel1),
`endif
    .piValid  (valid1),
    .poReady  (ready1),
    .poE      (e1),
    .poSel    (osel1),
    .poStrobe (strobe1),
    .poWrap   (wrap1),
    .poBusy   (busy1)
  );

  typedef struct {
    logic       valid;
    logic [3:0] data;
    logic [1:0] sel_in;
    logic       exp_ready;   // checked before the edge
    logic [3:0] exp_e;       // remaining fields checked after the edge
    logic [1:0] exp_sel;
    logic       exp_strobe;
    logic       exp_wrap;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] words [5];
    words[0] = 4'hA; words[1] = 4'hB; words[2] = 4'hC;
    words[3] = 4'hD; words[4] = 4'hE;

    // Continuous valid, HOLD_CYCLES=4: word k accepted at row 4k.
    for (int i = 0; i <= 16; i++) begin
      tbl[i].valid      = 1'b1;
      tbl[i].data       = words[i/4];
      tbl[i].sel_in     = 2'((i/4) % 4);
      tbl[i].exp_ready  = (i % 4 == 0);
      tbl[i].exp_e      = words[i/4];
      tbl[i].exp_sel    = 2'((i/4) % 4);
      tbl[i].exp_strobe = (i % 4 == 0);
      tbl[i].exp_wrap   = (i == 12);
      tbl[i].exp_busy   = 1'b1;
    end
    // Then idle: three more dwell cycles, then back to IDLE; poE retains E.
    for (int i = 17; i <= 20; i++) begin
      tbl[i].valid      = 1'b0;
      tbl[i].data       = 4'hF;
      tbl[i].sel_in     = 2'd3;
      tbl[i].exp_ready  = (i == 20);
      tbl[i].exp_e      = 4'hE;
      tbl[i].exp_sel    = 2'd0;
      tbl[i].exp_strobe = 1'b0;
      tbl[i].exp_wrap   = 1'b0;
      tbl[i].exp_busy   = (i != 20);
    end

    // ---------------- reset state ----------------
    #2;
    check("rst_ready4",  {31'd0, ready4}, 32'd1);
    check("rst_ready1",  {31'd0, ready1}, 32'd1);
    step(); step();
    rst = 1'b0;
    check("rst_e4",      {28'd0, e4}, 32'd0);
    check("rst_sel4",    {30'd0, osel4}, 32'd0);
    check("rst_strobe4", {31'd0, strobe4}, 32'd0);
    check("rst_wrap4",   {31'd0, wrap4}, 32'd0);
    check("rst_busy4",   {31'd0, busy4}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle_ready4",  {31'd0, ready4}, 32'd1);
      check("idle_strobe4", {31'd0, strobe4}, 32'd0);
      check("idle_e4",      {28'd0, e4}, 32'd0);
    end

    // ---------------- table: round-robin stream ----------------
    for (int i = 0; i < 21; i++) begin
      valid4 = tbl[i].valid;
      data4  = tbl[i].data;
      sel4   = tbl[i].sel_in;
      #1;
      check($sformatf("tbl%0d_ready", i), {31'd0, ready4}, {31'd0, tbl[i].exp_ready});
      step();
      check($sformatf("tbl%0d_e", i),      {28'd0, e4},      {28'd0, tbl[i].exp_e});
      check($sformatf("tbl%0d_sel", i),    {30'd0, osel4},   {30'd0, tbl[i].exp_sel});
      check($sformatf("tbl%0d_strobe", i), {31'd0, strobe4}, {31'd0, tbl[i].exp_strobe});
      check($sformatf("tbl%0d_wrap", i),   {31'd0, wrap4},   {31'd0, tbl[i].exp_wrap});
      check($sformatf("tbl%0d_busy", i),   {31'd0, busy4},   {31'd0, tbl[i].exp_busy});
    end

    // ---------------- single word, then idle (pointer now at 1) ----------------
    valid4 = 1'b1; data4 = 4'h5; sel4 = 2'd1;
    #1;
    check("single_ready", {31'd0, ready4}, 32'd1);
    step();
    valid4 = 1'b0; data4 = 4'h0;
    check("single_e",      {28'd0, e4}, 32'h5);
    check("single_sel",    {30'd0, osel4}, 32'd1);
    check("single_strobe", {31'd0, strobe4}, 32'd1);
    check("single_busy0",  {31'd0, busy4}, 32'd1);
    for (int k = 1; k < 4; k++) begin
      step();
      check($sformatf("single_busy%0d", k), {31'd0, busy4}, 32'd1);
      check($sformatf("single_nostrobe%0d", k), {31'd0, strobe4}, 32'd0);
    end
    step();
    check("single_idle", {31'd0, busy4}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("single_hold_e%0d", k), {28'd0, e4}, 32'h5);
    end

    // ---------------- reset in 2nd HOLD cycle (pointer now at 2) ----------------
    valid4 = 1'b1; data4 = 4'h7; sel4 = 2'd2;
    step();
    valid4 = 1'b0;
    check("mid_sel_before", {30'd0, osel4}, 32'd2);
    check("mid_e_before",   {28'd0, e4}, 32'h7);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_sel",   {30'd0, osel4}, 32'd0);
    check("mid_rst_e",     {28'd0, e4}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy4}, 32'd0);
    check("mid_rst_ready", {31'd0, ready4}, 32'd1);
    step();
    rst = 1'b0;
    valid4 = 1'b1; data4 = 4'h9; sel4 = 2'd0;
    step();
    valid4 = 1'b0;
    check("post_rst_sel",    {30'd0, osel4}, 32'd0);
    check("post_rst_e",      {28'd0, e4}, 32'h9);
    check("post_rst_strobe", {31'd0, strobe4}, 32'd1);
    check("post_rst_wrap",   {31'd0, wrap4}, 32'd0);

    // ---------------- HOLD_CYCLES=1 instance ----------------
`ifdef DEMUX_SEQ_TAG_EN
    begin
      logic [1:0] tsel [3];
      logic       twrp [3];
      tsel[0] = 2'd3; tsel[1] = 2'd3; tsel[2] = 2'd1;
      twrp[0] = 1'b1; twrp[1] = 1'b1; twrp[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        valid1 = 1'b1; data1 = 4'(i + 1); sel1 = tsel[i];
        #1;
        check($sformatf("tag%0d_ready", i), {31'd0, ready1}, 32'd1);
        step();
        check($sformatf("tag%0d_e", i),    {28'd0, e1}, 32'(i + 1));
        check($sformatf("tag%0d_sel", i),  {30'd0, osel1}, {30'd0, tsel[i]});
        check($sformatf("tag%0d_wrap", i), {31'd0, wrap1}, {31'd0, twrp[i]});
      end
    end
`endif
    for (int i = 0; i < 6; i++) begin
      valid1 = 1'b1; data1 = 4'(i + 3); sel1 = 2'(i % 4);
      #1;
      check($sformatf("h1_%0d_ready", i), {31'd0, ready1}, 32'd1);
      step();
      check($sformatf("h1_%0d_e", i),      {28'd0, e1}, 32'(i + 3));
      check($sformatf("h1_%0d_strobe", i), {31'd0, strobe1}, 32'd1);
`ifndef DEMUX_SEQ_TAG_EN
      check($sformatf("h1_%0d_sel", i),    {30'd0, osel1}, 32'(i % 4));
      check($sformatf("h1_%0d_wrap", i),   {31'd0, wrap1}, {31'd0, (i == 3)});
`else
      check($sformatf("h1_%0d_sel", i),    {30'd0, osel1}, 32'(i % 4));
`endif
      check($sformatf("h1_%0d_busy", i),   {31'd0, busy1}, 32'd1);
    end
    valid1 = 1'b0;
    #1;
    check("h1_end_ready", {31'd0, ready1}, 32'd1);
    step();
    check("h1_end_strobe", {31'd0, strobe1}, 32'd0);
    check("h1_end_busy",   {31'd0, busy1}, 32'd0);
    check("h1_end_e",      {28'd0, e1}, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_seq_4ch.md
# demux_seq_4ch

Upstream sequencer for the 4-channel demultiplexer. It accepts 4-bit words over a valid/ready handshake and assigns each word to an output channel in round-robin order. It drives the demultiplexer's data and select inputs (poE → piE, poSel → piSel) and holds each word stable for a programmable dwell time. All outputs are registered, so the demultiplexer always sees glitch-free, simultaneous data/select changes.

## Interface
Parameters:
- DATA_W, 4, word width; must equal the demux data width.
- HOLD_CYCLES, 4, cycles each accepted word stays presented before the next can be accepted; legal range 1..255, 0 is an elaboration error.

Ports:
- piClk  in  1  clock; all state updates on rising edge.
- piRst  in  1  reset, asynchronous, active-high.
- piData  in  DATA_W  input word.
- piValid  in  1  piData is valid.
- poReady  out  1  block will accept piData this cycle.
- poE  out  DATA_W  word presented to the demux.
- poSel  out  2  channel of poE.
- poStrobe  out  1  one-cycle pulse: poE/poSel just updated.
- poWrap  out  1  one-cycle pulse, coincident with poStrobe, when poSel updated to 3.
- poBusy  out  1  state is HOLD.

## Operation
- FSM has two states, IDLE and HOLD; reset state is IDLE.
- Internal state: 2-bit channel pointer `ptr`, reset 0; dwell counter `cnt`, width $clog2(HOLD_CYCLES+1), reset 0.
- poReady = (state==IDLE) || (state==HOLD && cnt==0). It is combinational from state only, never from piValid.
- Accept = piValid && poReady. On accept:
  - poE ← piData, poSel ← ptr, ptr ← ptr+1 (3 wraps to 0).
  - poStrobe ← 1; poWrap ← (ptr==3).
  - cnt ← HOLD_CYCLES-1; state ← HOLD.
- HOLD without accept: cnt decrements while nonzero. When cnt==0 and piValid=0, state ← IDLE.
- HOLD with cnt==0 and an accept: reload back-to-back, with no IDLE bubble.
- poE/poSel hold their last value indefinitely; they never return to zero. This lets the downstream demux retain each channel's value.
- poStrobe/poWrap are 0 on every cycle without an accept.
- HOLD_CYCLES=1: poReady stays high, giving one word per cycle.
- piValid dropping before acceptance has no effect; there is no data capture without a handshake.

## Timing
- Reset values: poE=0, poSel=0, poStrobe=0, poWrap=0, poBusy=0. poReady is 1 during and after reset.
- Reset asserted mid-HOLD immediately forces IDLE and ptr=0. The pending dwell is discarded.
- Latency is 1: accept at edge N, so poE/poSel/poStrobe change right after edge N.
- Throughput is one word per HOLD_CYCLES cycles under continuous piValid.
- Minimum spacing between poStrobe pulses is HOLD_CYCLES cycles.
- poBusy is high for exactly HOLD_CYCLES cycles after an isolated accept.

## Configuration
- Macro DEMUX_SEQ_TAG_EN.
- When defined:
  - Adds input piSel (2 bits), sampled with piData.
  - On accept, poSel ← piSel and ptr is unused (held at 0).
  - poWrap pulses when the captured piSel==3.
- When undefined: round-robin ptr as above, and no piSel port exists.
- Handshake and timing are identical in both builds.

## Structure
- Package demux_seq_pkg holds:
  - NUM_CH=4 and SEL_W=2.
  - State enum {ST_IDLE, ST_HOLD}.
  - A function computing the counter width from HOLD_CYCLES.
- Sub-module demux_seq_dwell_cnt: a loadable down-counter with load value, load enable, and zero flag. The top level contains the FSM, pointer and output registers.

## Test plan
- Reset release, HOLD_CYCLES=4, piValid=0 → poE=0, poSel=0, poReady=1, no strobes.
- Words 0xA,0xB,0xC,0xD,0xE held valid continuously, HOLD_CYCLES=4 → poSel sequence 0,1,2,3,0 with strobes exactly 4 cycles apart. poWrap pulses only with 0xD. Fifth word lands on channel 0.
- HOLD_CYCLES=1, continuous valid → one accept per cycle, poReady never low, poStrobe constantly high.
- Single word 0x5, then idle → poBusy high 4 cycles, then IDLE. poE stays 0x5 for 20+ cycles.
- piRst pulsed in the 2nd HOLD cycle after accepting on channel 2 → poSel=0, poE=0, ptr=0. The next word goes to channel 0.
- DEMUX_SEQ_TAG_EN build, piSel=3,3,1 with data 0x1,0x2,0x3 → poSel=3,3,1. poWrap pulses for the first two words.
